// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: parity modes, receiver states,
// reset bit-period calculation and the expected-parity function.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    function automatic int default_period(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Parity bit the transmitter should have sent for this byte.
    function automatic logic parity_expected(input logic [7:0] data, input parity_t par);
        logic exp_s;
        case (par)
            PAR_ODD:  exp_s = ~^data;
            PAR_EVEN: exp_s = ^data;
            default:  exp_s = 1'b0;
        endcase
        return exp_s;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; flops reset to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values of the synchroniser chain.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB first, optional parity, 1 stop bit.
// Bit period and parity mode are latched at frame start; one-cycle valid per good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int PERIOD_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_bit_period_i,
    input  logic [PERIOD_W-1:0] bit_period_i,
    input  logic [1:0]          parity_type_i,
    input  logic                uart_rxd,
    input  logic                uart_rx_en,
    output logic                uart_rx_valid_o,
    output logic [7:0]          uart_rx_data,
    output logic                uart_rx_parity_error_o
);

    localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(default_period(CLK_FREQ, BAUD_RATE));
    localparam logic [PERIOD_W-1:0] P_ONE      = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] P_TWO      = PERIOD_W'(2);

    logic                rxd_s;
    logic                tick_s;
    logic [PERIOD_W-1:0] target_s;

    rx_state_t           state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cur_period_q, cur_period_d;
    parity_t             par_q, par_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                perr_frame_q, perr_frame_d;
    logic                valid_q, valid_d;
    logic [7:0]          data_q, data_d;
    logic                perr_q, perr_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rxd (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (uart_rxd),
        .q_o   (rxd_s)
    );

    // Sample strobe: half a period into the start bit, full periods afterwards.
    always_comb begin
        if (state_q == START) begin
            target_s = cur_period_q >> 1;
        end else begin
            target_s = cur_period_q;
        end
        tick_s = (cnt_q == (target_s - P_ONE));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (uart_rx_en && !rxd_s) state_d = START; else state_d = IDLE;
            START:  if (tick_s) state_d = rxd_s ? IDLE : DATA; else state_d = START;
            DATA: begin
                if (tick_s && (bit_idx_q == 3'd7)) begin
                    state_d = ((par_q == PAR_ODD) || (par_q == PAR_EVEN)) ? PARITY : STOP;
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: if (tick_s) state_d = STOP; else state_d = PARITY;
            STOP:   if (tick_s) state_d = rxd_s ? IDLE : BREAK; else state_d = STOP;
            BREAK:  if (rxd_s) state_d = IDLE; else state_d = BREAK;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        period_d     = period_q;
        cur_period_d = cur_period_q;
        par_d        = par_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        perr_frame_d = perr_frame_q;
        valid_d      = 1'b0;
        data_d       = data_q;
        perr_d       = perr_q;

        if (wr_bit_period_i) begin
            period_d = (bit_period_i < P_TWO) ? P_TWO : bit_period_i;
        end else begin
            period_d = period_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d        = '0;
                bit_idx_d    = 3'd0;
                perr_frame_d = 1'b0;
                cur_period_d = period_q;
                case (parity_type_i)
                    2'd1:    par_d = PAR_ODD;
                    2'd2:    par_d = PAR_EVEN;
                    default: par_d = PAR_NONE;
                endcase
            end
            START: begin
                cnt_d = tick_s ? '0 : (cnt_q + P_ONE);
            end
            DATA: begin
                cnt_d = tick_s ? '0 : (cnt_q + P_ONE);
                if (tick_s) begin
                    shift_d[bit_idx_q] = rxd_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
            PARITY: begin
                cnt_d = tick_s ? '0 : (cnt_q + P_ONE);
                if (tick_s) begin
                    perr_frame_d = (rxd_s != parity_expected(shift_q, par_q));
                end else begin
                    perr_frame_d = perr_frame_q;
                end
            end
            STOP: begin
                cnt_d = tick_s ? '0 : (cnt_q + P_ONE);
                // A low stop bit is a framing error: nothing is delivered.
                if (tick_s && rxd_s) begin
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    perr_d  = perr_frame_q;
                end else begin
                    valid_d = 1'b0;
                end
            end
            BREAK: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q     <= RST_PERIOD;
            cur_period_q <= RST_PERIOD;
            par_q        <= PAR_NONE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            perr_frame_q <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= 8'h00;
            perr_q       <= 1'b0;
        end else begin
            period_q     <= period_d;
            cur_period_q <= cur_period_d;
            par_q        <= par_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            perr_frame_q <= perr_frame_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            perr_q       <= perr_d;
        end
    end

    assign uart_rx_valid_o        = valid_q;
    assign uart_rx_data           = data_q;
    assign uart_rx_parity_error_o = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are serialised by the bench, expected bytes
// go into a scoreboard queue and are compared when the receiver pulses valid.
module tb_uart_rx;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        wr_bit_period_i;
    logic [15:0] bit_period_i;
    logic [1:0]  parity_type_i;
    logic        uart_rxd;
    logic        uart_rx_en;
    logic        uart_rx_valid_o;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_parity_error_o;

    exp_t sb_q[$];
    int   passed;
    int   total;
    int   cyc;
    int   rx_cnt;
    int   last_valid_cyc;
    logic prev_valid;

    uart_rx dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .wr_bit_period_i        (wr_bit_period_i),
        .bit_period_i           (bit_period_i),
        .parity_type_i          (parity_type_i),
        .uart_rxd               (uart_rxd),
        .uart_rx_en             (uart_rx_en),
        .uart_rx_valid_o        (uart_rx_valid_o),
        .uart_rx_data           (uart_rx_data),
        .uart_rx_parity_error_o (uart_rx_parity_error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Serialise one frame; the line is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [7:0] d, input int per, input int par_mode,
                              input logic flip_par, input logic stop_bit);
        uart_rxd = 1'b0;
        repeat (per) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            repeat (per) @(posedge clk);
        end
        if (par_mode != 0) begin
            uart_rxd = ((par_mode == 1) ? ~^d : ^d) ^ flip_par;
            repeat (per) @(posedge clk);
        end
        uart_rxd = stop_bit;
        repeat (per) @(posedge clk);
    endtask

    task automatic write_period(input logic [15:0] p);
        @(posedge clk);
        wr_bit_period_i = 1'b1;
        bit_period_i    = p;
        @(posedge clk);
        wr_bit_period_i = 1'b0;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_n && uart_rx_valid_o) begin
            exp_t e;
            rx_cnt++;
            last_valid_cyc = cyc;
            check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
            check("valid_expected", {31'd0, (sb_q.size() > 0)}, 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rx_data", {24'd0, uart_rx_data}, {24'd0, e.d});
                check("rx_parity_err", {31'd0, uart_rx_parity_error_o}, {31'd0, e.e});
            end
        end
        prev_valid = uart_rx_valid_o;
    end

    initial begin
        int start_cyc;
        int lat;
        passed = 0; total = 0; cyc = 0; rx_cnt = 0; last_valid_cyc = 0; prev_valid = 1'b0;
        rst_n = 1'b0; wr_bit_period_i = 1'b0; bit_period_i = 16'd0;
        parity_type_i = 2'd0; uart_rxd = 1'b1; uart_rx_en = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {31'd0, uart_rx_valid_o}, 32'd0);
        check("reset_data", {24'd0, uart_rx_data}, 32'd0);
        check("reset_perr", {31'd0, uart_rx_parity_error_o}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // 0xA5, no parity, default period 217
        sb_q.push_back('{d: 8'hA5, e: 1'b0});
        start_cyc = cyc;
        send_frame(8'hA5, 217, 0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        check("a5_count", rx_cnt, 32'd1);
        lat = last_valid_cyc - start_cyc;
        check("a5_latency_window", {31'd0, (lat >= 2055 && lat <= 2080)}, 32'd1);

        // Odd parity, good then bad parity bit
        parity_type_i = 2'd1;
        sb_q.push_back('{d: 8'h3C, e: 1'b0});
        send_frame(8'h3C, 217, 1, 1'b0, 1'b1);
        sb_q.push_back('{d: 8'h3C, e: 1'b1});
        send_frame(8'h3C, 217, 1, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        check("odd_count", rx_cnt, 32'd3);
        check("odd_perr_hold", {31'd0, uart_rx_parity_error_o}, 32'd1);

        // Framing error on 0x55, line held low, then 0x12
        parity_type_i = 2'd0;
        send_frame(8'h55, 217, 0, 1'b0, 1'b0);
        repeat (3 * 217) @(posedge clk);
        uart_rxd = 1'b1;
        repeat (217) @(posedge clk);
        check("frame_err_count", rx_cnt, 32'd3);
        check("frame_err_data_hold", {24'd0, uart_rx_data}, 32'h3C);
        sb_q.push_back('{d: 8'h12, e: 1'b0});
        send_frame(8'h12, 217, 0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        check("after_break_count", rx_cnt, 32'd4);

        // 50-clock low glitch
        uart_rxd = 1'b0;
        repeat (50) @(posedge clk);
        uart_rxd = 1'b1;
        repeat (400) @(posedge clk);
        check("glitch_count", rx_cnt, 32'd4);

        // Period 16, back-to-back frames, even parity on the last one
        write_period(16'd16);
        repeat (4) @(posedge clk);
        sb_q.push_back('{d: 8'h00, e: 1'b0});
        sb_q.push_back('{d: 8'hFF, e: 1'b0});
        send_frame(8'h00, 16, 0, 1'b0, 1'b1);
        send_frame(8'hFF, 16, 0, 1'b0, 1'b1);
        parity_type_i = 2'd2;
        sb_q.push_back('{d: 8'h81, e: 1'b0});
        send_frame(8'h81, 16, 2, 1'b0, 1'b1);
        repeat (40) @(posedge clk);
        check("b2b_count", rx_cnt, 32'd7);

        // Period write below minimum clamps to 2
        parity_type_i = 2'd0;
        write_period(16'd0);
        repeat (4) @(posedge clk);
        sb_q.push_back('{d: 8'hC3, e: 1'b0});
        send_frame(8'hC3, 2, 0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        check("clamp_count", rx_cnt, 32'd8);

        // Receiver disabled
        write_period(16'd16);
        uart_rx_en = 1'b0;
        repeat (4) @(posedge clk);
        send_frame(8'h77, 16, 0, 1'b0, 1'b1);
        repeat (40) @(posedge clk);
        check("disabled_count", rx_cnt, 32'd8);
        check("disabled_data_hold", {24'd0, uart_rx_data}, 32'hC3);
        uart_rx_en = 1'b1;
        repeat (4) @(posedge clk);

        // Reset mid-frame
        uart_rxd = 1'b0;
        repeat (16 * 4) @(posedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset_valid", {31'd0, uart_rx_valid_o}, 32'd0);
        check("midreset_data", {24'd0, uart_rx_data}, 32'd0);
        check("midreset_perr", {31'd0, uart_rx_parity_error_o}, 32'd0);
        uart_rxd = 1'b1;
        repeat (5) @(posedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("midreset_count", rx_cnt, 32'd8);
        sb_q.push_back('{d: 8'h5A, e: 1'b0});
        send_frame(8'h5A, 217, 0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        check("post_reset_count", rx_cnt, 32'd9);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
